// File: rtl/calc_pkg.sv
// Shared types for the handshaked calculator: opcodes, FSM states, status flags.
// Latency: none (types only).
// Backpressure: n/a.
package calc_pkg;

    typedef enum logic [2:0] {
        OP_ADDU = 3'd0,
        OP_SUBU = 3'd1,
        OP_ADDS = 3'd2,
        OP_SUBS = 3'd3,
        OP_CMPU = 3'd4,
        OP_CMPS = 3'd5,
        OP_MULU = 3'd6,
        OP_RSVD = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
        logic err;
    } flags_t;

    // bit positions of the one-hot compare result
    localparam int CMP_LT = 0;
    localparam int CMP_EQ = 1;
    localparam int CMP_GT = 2;

endpackage

// File: rtl/calc_mul_seq.sv
// Unsigned W x W shift-add multiplier, one partial product per cycle.
// Latency: first partial product on start, done after W-1 further cycles.
// Backpressure: none; caller holds off start until done.
module calc_mul_seq
    import calc_pkg::*;
#(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           done,
    output logic [2*W-1:0] prod
);

    localparam int CW = $clog2(W);

    logic [2*W-1:0] acc_q;
    logic [2*W-1:0] mcand_q;
    logic [W-1:0]   mplier_q;
    logic [CW-1:0]  cnt_q;
    logic           busy_q;
    logic [2*W-1:0] pp;

    // prod already includes the current partial product, so the top can
    // capture it on the same edge that done is seen
    assign pp   = mplier_q[0] ? mcand_q : '0;
    assign prod = acc_q + pp;
    assign done = busy_q && (cnt_q == CW'(W - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start) begin
            acc_q    <= b[0] ? {{W{1'b0}}, a} : '0;
            mcand_q  <= {{(W-1){1'b0}}, a, 1'b0};
            mplier_q <= b >> 1;
            cnt_q    <= CW'(1);
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            acc_q    <= prod;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            if (done) begin
                busy_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                cnt_q  <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/calc_seq.sv
// Handshaked W-bit calculator: add/sub/compare in one cycle, shift-add multiply in W.
// Latency: result valid 1 cycle after accept (W cycles for MULU); one op in flight.
// Backpressure: result held stable until out_ready; in_ready low until it drains.
module calc_seq
    import calc_pkg::*;
#(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [2:0]     op,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] y,
    output logic           cout,
    output logic           ovf,
    output logic           zero,
    output logic           err
);

    state_e         state_q;
    state_e         state_d;
    logic [2*W-1:0] y_q;
    flags_t         flags_q;

    logic           accept;
    logic           is_mul;
    logic           mul_done;
    logic [2*W-1:0] mul_prod;
    flags_t         mul_f;

    logic [W:0]     sum_u;
    logic [W:0]     dif_u;
    logic [W:0]     a_s;
    logic [W:0]     b_s;
    logic [W:0]     sum_s;
    logic [W:0]     dif_s;
    logic [2*W-1:0] alu_y;
    flags_t         alu_f;

    assign is_mul = (op_e'(op) == OP_MULU);
    assign accept = in_valid && in_ready;

    calc_mul_seq #(.W(W)) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (accept && is_mul),
        .a     (a),
        .b     (b),
        .done  (mul_done),
        .prod  (mul_prod)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = is_mul ? MUL : DONE;
                end
            end
            MUL: begin
                if (mul_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // W+1-bit arithmetic keeps the true carry/borrow and signed result
    assign sum_u = {1'b0, a} + {1'b0, b};
    assign dif_u = {1'b0, a} - {1'b0, b};
    assign a_s   = {a[W-1], a};
    assign b_s   = {b[W-1], b};
    assign sum_s = a_s + b_s;
    assign dif_s = a_s - b_s;

    always_comb begin
        alu_y = '0;
        alu_f = '0;
        case (op_e'(op))
            OP_ADDU: begin
                alu_y      = {{(W-1){1'b0}}, sum_u};
                alu_f.cout = sum_u[W];
            end
            OP_SUBU: begin
                alu_y      = {{(W-1){1'b0}}, dif_u};
                alu_f.cout = (a < b);
            end
            OP_ADDS: begin
                alu_y     = {{(W-1){sum_s[W]}}, sum_s};
                alu_f.ovf = sum_s[W] ^ sum_s[W-1];
            end
            OP_SUBS: begin
                alu_y     = {{(W-1){dif_s[W]}}, dif_s};
                alu_f.ovf = dif_s[W] ^ dif_s[W-1];
            end
            OP_CMPU: begin
                alu_y[CMP_GT] = (a > b);
                alu_y[CMP_EQ] = (a == b);
                alu_y[CMP_LT] = (a < b);
            end
            OP_CMPS: begin
                alu_y[CMP_GT] = ($signed(a) > $signed(b));
                alu_y[CMP_EQ] = (a == b);
                alu_y[CMP_LT] = ($signed(a) < $signed(b));
            end
            OP_RSVD: begin
                alu_f.err = 1'b1;
            end
            default: begin
                alu_y = '0;
            end
        endcase
        alu_f.zero = (alu_y == '0);
    end

    always_comb begin
        mul_f      = '0;
        mul_f.zero = (mul_prod == '0);
    end

    // The result register only loads on accept or multiply completion,
    // so it stays frozen while the sink stalls in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q     <= '0;
            flags_q <= '0;
        end else if (accept && !is_mul) begin
            y_q     <= alu_y;
            flags_q <= alu_f;
        end else if (state_q == MUL && mul_done) begin
            y_q     <= mul_prod;
            flags_q <= mul_f;
        end
    end

    assign y    = y_q;
    assign cout = flags_q.cout;
    assign ovf  = flags_q.ovf;
    assign zero = flags_q.zero;
    assign err  = flags_q.err;

endmodule

// File: tb/tb_calc_seq.sv
// Directed and random checks of calc_seq against an arithmetic reference model.
module tb_calc_seq;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic [2:0]     op = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*W-1:0] y;
    logic           cout;
    logic           ovf;
    logic           zero;
    logic           err;

    int total = 0;
    int bad   = 0;

    calc_seq #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic. Returns {y, cout, ovf, zero, err}.
    function automatic logic [2*W+3:0] model(input int o, input int av, input int bv);
        int   sa, sb, r;
        logic c, v, e;
        c  = 1'b0;
        v  = 1'b0;
        e  = 1'b0;
        sa = (av >= (1 << (W-1))) ? av - (1 << W) : av;
        sb = (bv >= (1 << (W-1))) ? bv - (1 << W) : bv;
        case (o)
            0: begin r = av + bv; c = (r >= (1 << W)); end
            1: begin r = av - bv; c = (av < bv); if (r < 0) r += (1 << (W+1)); end
            2: begin r = sa + sb; v = (r > (1 << (W-1)) - 1) || (r < -(1 << (W-1))); end
            3: begin r = sa - sb; v = (r > (1 << (W-1)) - 1) || (r < -(1 << (W-1))); end
            4: r = (av > bv) ? 4 : (av == bv) ? 2 : 1;
            5: r = (sa > sb) ? 4 : (sa == sb) ? 2 : 1;
            6: r = av * bv;
            default: begin r = 0; e = 1'b1; end
        endcase
        r = r & ((1 << (2*W)) - 1);
        return {r[2*W-1:0], c, v, (r == 0), e};
    endfunction

    task automatic run_op(input string tag, input int o, input int av, input int bv);
        logic [2*W+3:0] e;
        int lat;
        e = model(o, av, bv);
        chk({tag, ".in_ready_idle"}, in_ready, 1);
        in_valid = 1'b1;
        op = 3'(o);
        a  = W'(av);
        b  = W'(bv);
        @(posedge clk); #1;
        // operands must already be captured; scramble them
        in_valid = 1'b0;
        a  = W'($urandom);
        b  = W'($urandom);
        op = 3'($urandom);
        lat = 1;
        while (!out_valid && lat < 40) begin
            chk({tag, ".in_ready_busy"}, in_ready, 0);
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ".latency"}, lat, (o == 6) ? W : 1);
        chk({tag, ".y"},    y,    e[2*W+3:4]);
        chk({tag, ".cout"}, cout, e[3]);
        chk({tag, ".ovf"},  ovf,  e[2]);
        chk({tag, ".zero"}, zero, e[1]);
        chk({tag, ".err"},  err,  e[0]);
        chk({tag, ".in_ready_done"}, in_ready, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, ".out_valid_drained"}, out_valid, 0);
        chk({tag, ".in_ready_after"}, in_ready, 1);
    endtask

    initial begin
        int lat;

        #1 rst = 1'b1;
        #1;
        chk("reset.out_valid", out_valid, 0);
        chk("reset.in_ready", in_ready, 1);
        chk("reset.y", y, 0);
        chk("reset.flags", {cout, ovf, zero, err}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_op("addu_15_1", 0, 15, 1);
        run_op("subu_3_5", 1, 3, 5);
        run_op("subs_7_m1", 3, 7, 15);
        run_op("adds_m8_m1", 2, 8, 15);
        run_op("cmps_m8_1", 5, 8, 1);
        run_op("cmpu_8_1", 4, 8, 1);
        run_op("cmpu_eq", 4, 6, 6);
        run_op("mulu_15_15", 6, 15, 15);
        run_op("mulu_0_9", 6, 0, 9);
        run_op("rsvd", 7, 5, 3);

        for (int i = 0; i < 40; i++) begin
            run_op("rand", $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15));
        end

        // sink stall: result frozen, a second request is refused
        in_valid = 1'b1; op = 3'd0; a = 4'd9; b = 4'd5;
        @(posedge clk); #1;
        op = 3'd6; a = 4'd3; b = 4'd7;
        chk("stall.first_valid", out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("stall.y", y, 14);
            chk("stall.out_valid", out_valid, 1);
            chk("stall.in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("stall.release_valid", out_valid, 0);
        chk("stall.release_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("stall.second_accepted", in_ready, 0);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("stall.second_latency", lat, W);
        chk("stall.second_y", y, 21);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // reset in the middle of a multiply
        in_valid = 1'b1; op = 3'd6; a = 4'd15; b = 4'd15;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rst_mul.out_valid", out_valid, 0);
        chk("rst_mul.y", y, 0);
        chk("rst_mul.in_ready", in_ready, 1);
        chk("rst_mul.flags", {cout, ovf, zero, err}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_op("rsvd_after_rst", 7, 9, 9);

        // reset while a result is being held
        in_valid = 1'b1; op = 3'd0; a = 4'd15; b = 4'd1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rst_hold.y_before", y, 16);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rst_hold.out_valid", out_valid, 0);
        chk("rst_hold.y", y, 0);
        chk("rst_hold.cout", cout, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_op("mulu_after_rst", 6, 13, 11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
